act_skew_feeder: RTL and testbench

- Upstream stage of the 10x10 weight-stationary systolic array.
- Accepts one NxN signed activation matrix, one row per beat, over a valid/ready handshake, and buffers it.
- Replays the matrix as a diagonally skewed stream of N lanes. Each lane drives the left-edge activation input of one array row.
- Replaces ad-hoc in-array injection logic; the array consumes out_iact directly each beat.

---
 rtl/act_skew_feeder.sv | 130 +++++++++++++
 tb/tb_act_skew_feeder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/act_skew_feeder.sv
// Buffers one NxN activation matrix row by row and replays it as a diagonally skewed N-lane stream.
// Optional FEEDER_PINGPONG_EN adds a shadow buffer so the next matrix loads while the current one streams.
module act_skew_feeder #(
  parameter int N  = 10,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_row,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [N*DW-1:0] out_iact,
  output logic            out_first,
  output logic            out_last,
  output logic            done
);
  localparam int RW = $clog2(N + 1);
  localparam int TW = $clog2(2 * N - 1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);
  localparam logic [RW-1:0] R_FULL = RW'(N);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

`ifdef FEEDER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic [1:0]      state;
  logic [RW-1:0]   row_cnt;
  logic [RW-1:0]   nrow;
  logic [TW-1:0]   beat;
  logic            sel;
  logic            wbank;
  logic            acc;
  logic [N*DW-1:0] mem [2][N];

  assign acc   = in_valid & in_ready;
  assign nrow  = row_cnt + RW'(acc);
  // sel is the bank being streamed; loads land in the other bank only when ping-pong is built in
  assign wbank = PP ? ~sel : sel;

  always_ff @(posedge clk) begin
    if (acc) mem[wbank][row_cnt] <= in_row;
  end

  function automatic logic [N*DW-1:0] skew(input logic bank, input logic [TW-1:0] t);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = int'(t) - i;
      if (d >= 0 && d < N) v[i*DW +: DW] = mem[bank][i][(N-1-d)*DW +: DW];
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      beat      <= '0;
      sel       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_iact  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (acc) row_cnt <= nrow;
      case (state)
        IDLE, LOAD: begin
          in_ready <= 1'b1;
          if (acc) begin
            state <= LOAD;
            if (nrow == R_FULL) begin
              // beat 0 only needs row 0, which is already in the buffer
              state     <= STREAM;
              row_cnt   <= '0;
              in_ready  <= PP;
              sel       <= PP ? ~sel : sel;
              beat      <= '0;
              out_valid <= 1'b1;
              out_iact  <= skew(wbank, '0);
              out_first <= 1'b1;
              out_last  <= 1'b0;
            end
          end
        end
        STREAM: begin
          in_ready <= PP && (nrow < R_FULL);
          if (out_ready) begin
            if (beat == T_LAST) begin
              done <= 1'b1;
              if (PP && nrow == R_FULL) begin
                sel       <= ~sel;
                row_cnt   <= '0;
                in_ready  <= 1'b1;
                beat      <= '0;
                out_iact  <= skew(wbank, '0);
                out_first <= 1'b1;
                out_last  <= 1'b0;
              end else begin
                state     <= (PP && nrow != '0) ? LOAD : IDLE;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
                out_iact  <= '0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
              end
            end else begin
              beat      <= beat + 1'b1;
              out_iact  <= skew(sel, beat + 1'b1);
              out_first <= 1'b0;
              out_last  <= (beat + 1'b1 == T_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_act_skew_feeder.sv
// Randomized bench for act_skew_feeder (default single-buffer build) against a row-placement stream model.
`timescale 1ns/1ps
module tb_act_skew_feeder;
  localparam int N  = 10;
  localparam int DW = 16;
  localparam int W  = N * DW;
  localparam int NB = 2 * N - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_row = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_iact;
  logic         out_first;
  logic         out_last;
  logic         done;

  int n_chk = 0;
  int n_pass = 0;
  int acc_cnt = 0;

  logic [DW-1:0] m [N][N];
  logic [W-1:0]  expb [NB];
  logic [W-1:0]  cap [NB];

  always #5 clk = ~clk;

  act_skew_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_ready(out_ready), .out_valid(out_valid), .out_iact(out_iact),
    .out_first(out_first), .out_last(out_last), .done(done)
  );

  // input handshakes that will complete at the next rising edge
  always @(negedge clk) if (in_valid && in_ready) acc_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        case (mode)
          0:       m[r][c] = DW'(100 * r + c + 1);
          1:       m[r][c] = DW'(-(c + 1));
          default: m[r][c] = DW'($urandom);
        endcase
  endtask

  // each row lands on its own lane, column-reversed, starting i beats late; everything else pads to 0
  task automatic build_model();
    for (int t = 0; t < NB; t++) expb[t] = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        expb[i + k][i*DW +: DW] = m[i][N-1-k];
  endtask

  task automatic load(input int gap_row, input int gap_len);
    int r = 0;
    int bub = gap_len;
    int guard = 0;
    int a0 = acc_cnt;
    while (r < N && guard < 300) begin
      if (r == gap_row && bub > 0) begin
        in_valid = 1'b0;
        bub--;
      end else begin
        in_valid = 1'b1;
        for (int c = 0; c < N; c++) in_row[c*DW +: DW] = m[r][c];
        if (in_ready) r++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("rows accepted", W'(acc_cnt - a0), W'(N));
  endtask

  task automatic stream(input int stall_at, input int stall_len, input logic hold_valid, input int rst_at);
    int t = 0;
    int cyc = 0;
    int st = 0;
    int a0;
    build_model();
    if (hold_valid) begin
      in_valid = 1'b1;
      in_row   = '1;
    end
    a0 = acc_cnt;
    while (t < NB && cyc < 300) begin
      if (t == rst_at) begin
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rst out_valid", W'(out_valid), W'(0));
        check("rst out_iact", out_iact, '0);
        check("rst in_ready", W'(in_ready), W'(0));
        check("rst done", W'(done), W'(0));
        rst = 1'b1;
        tick();
        check("post-rst in_ready", W'(in_ready), W'(1));
        for (int k = 0; k < 3; k++) begin
          tick();
          check("no replay", W'(out_valid), W'(0));
        end
        return;
      end
      out_ready = !(t == stall_at && st < stall_len);
      check($sformatf("out_valid t%0d", t), W'(out_valid), W'(1));
      check($sformatf("iact t%0d", t), out_iact, expb[t]);
      if (out_ready) begin
        check($sformatf("first t%0d", t), W'(out_first), W'(t == 0));
        check($sformatf("last t%0d", t), W'(out_last), W'(t == NB - 1));
        cap[t] = out_iact;
        t++;
      end else begin
        st++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("beats consumed", W'(t), W'(NB));
    check("done cycle", W'(cyc), W'(NB + stall_len));
    check("done high", W'(done), W'(1));
    check("end out_valid", W'(out_valid), W'(0));
    check("end out_iact", out_iact, '0);
    check("end in_ready", W'(in_ready), W'(1));
    if (hold_valid) check("no accept in stream", W'(acc_cnt - a0), W'(0));
    tick();
    check("done one cycle", W'(done), W'(0));
  endtask

  initial begin
    repeat (3) tick();
    check("reset in_ready", W'(in_ready), W'(0));
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset out_iact", out_iact, '0);
    check("reset out_first", W'(out_first), W'(0));
    check("reset out_last", W'(out_last), W'(0));
    check("reset done", W'(done), W'(0));
    rst = 1'b1;
    tick();
    check("idle in_ready", W'(in_ready), W'(1));
    out_ready = 1'b1;

    fill(0); load(-1, 0); stream(-1, 0, 1'b0, -1);
    check("basic b0 lane0", W'(cap[0][0 +: DW]), W'(10));
    check("basic b0 upper", W'(cap[0][W-1:DW]), '0);
    check("basic b9 lane0", W'(cap[9][0 +: DW]), W'(1));
    check("basic b9 lane9", W'(cap[9][9*DW +: DW]), W'(910));
    check("basic b18 lane9", W'(cap[18][9*DW +: DW]), W'(901));
    check("basic b18 lower", W'(cap[18][9*DW-1:0]), '0);

    fill(1); load(-1, 0); stream(-1, 0, 1'b0, -1);
    check("neg b0 lane0", W'(cap[0][0 +: DW]), W'(16'hFFF6));
    check("neg b1 lane1", W'(cap[1][DW +: DW]), W'(16'hFFF6));

    fill(2); load(-1, 0); stream(5, 3, 1'b0, -1);
    fill(2); load(4, 5);  stream(-1, 0, 1'b1, -1);
    fill(0); load(-1, 0); stream(-1, 0, 1'b0, 7);
    fill(2); load(-1, 0); stream(-1, 0, 1'b0, -1);
    for (int k = 0; k < 3; k++) begin
      fill(2);
      load($urandom_range(1, N - 1), $urandom_range(0, 4));
      stream($urandom_range(0, NB - 1), $urandom_range(0, 5), 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
